// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-pass controller for the immediate-amount barrel shifter
//
// Splits a register-specified shift (amount 0..255) into shifter passes of at
// most STEP_MAX bits. Each pass result is fed back as the next pass's Rm. The
// final {y, carry_out} is returned through a valid/ready handshake.
//
// Optional build macro: SHIFT_SEQ_SAT_EN
//   defined     : LSL/LSR/ASR amounts are clamped to 33 (at most 2 passes)
//   not defined : full iteration, ceil(amount/STEP_MAX) passes
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start_valid/start_ready       request handshake (ready only in IDLE)
//   rm, amount, shift_type,       request operands, sampled at accept
//   carry_in
//   result_valid/result_ready     result handshake (valid only in DONE)
//   y, carry_out                  result, held until the next result
//   busy                          state != IDLE
//   sh_en, sh_rm, sh_operand      drive to the external shifter
//   sh_y, sh_carry                combinational shifter result

module shift_sequencer #(
  parameter int STEP_MAX = 31,
  parameter int AMT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [31:0]      rm,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       shift_type,
  input  logic             carry_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [31:0]      y,
  output logic             carry_out,
  output logic             busy,
  output logic             sh_en,
  output logic [31:0]      sh_rm,
  output logic [11:0]      sh_operand,
  input  logic [31:0]      sh_y,
  input  logic             sh_carry
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DONE
  } state_t;

  localparam logic [AMT_W-1:0] STEP_MAX_A = AMT_W'(STEP_MAX);
  localparam logic [1:0]       SH_ROR     = 2'b11;
`ifdef SHIFT_SEQ_SAT_EN
  // 33 is the smallest amount whose result equals every larger amount.
  localparam logic [AMT_W-1:0] SAT_AMT    = AMT_W'(33);
`endif

  state_t           state;
  logic [31:0]      work;
  logic             c;
  logic [AMT_W-1:0] remaining;
  logic [1:0]       type_q;

  logic [AMT_W-1:0] step_amt;
  logic [AMT_W-1:0] start_rem;
  logic             zero_pass;

  // Never zero while in STEP, so the shifter never sees imm 0
  // (which would encode LSR32/ASR32/RRX instead of a no-op).
  always_comb begin
    step_amt = (remaining > STEP_MAX_A) ? STEP_MAX_A : remaining;
  end

  assign sh_rm      = work;
  assign sh_operand = {step_amt[4:0], type_q, 5'b0};

  // Pass plan computed from the request at accept time.
  always_comb begin
    zero_pass = (amount == '0) || ((shift_type == SH_ROR) && (amount[4:0] == 5'd0));
    if (shift_type == SH_ROR) begin
      start_rem = {{(AMT_W-5){1'b0}}, amount[4:0]};
    end else begin
`ifdef SHIFT_SEQ_SAT_EN
      start_rem = (amount > SAT_AMT) ? SAT_AMT : amount;
`else
      start_rem = amount;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      work         <= '0;
      c            <= 1'b0;
      remaining    <= '0;
      type_q       <= 2'b00;
      y            <= '0;
      carry_out    <= 1'b0;
      result_valid <= 1'b0;
      sh_en        <= 1'b0;
      start_ready  <= 1'b1;
      busy         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            type_q      <= shift_type;
            work        <= rm;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            if (zero_pass) begin
              // amount 0 keeps C; ROR by a multiple of 32 sets C from bit 31.
              c            <= (amount == '0) ? carry_in : rm[31];
              y            <= rm;
              carry_out    <= (amount == '0) ? carry_in : rm[31];
              result_valid <= 1'b1;
              state        <= S_DONE;
            end else begin
              c         <= carry_in;
              remaining <= start_rem;
              sh_en     <= 1'b1;
              state     <= S_STEP;
            end
          end
        end

        S_STEP: begin
          work      <= sh_y;
          c         <= sh_carry;
          remaining <= remaining - step_amt;
          if (remaining == step_amt) begin
            y            <= sh_y;
            carry_out    <= sh_carry;
            result_valid <= 1'b1;
            sh_en        <= 1'b0;
            state        <= S_DONE;
          end
        end

        S_DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            start_ready  <= 1'b1;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end
        end

        default: begin
          state        <= S_IDLE;
          result_valid <= 1'b0;
          sh_en        <= 1'b0;
          start_ready  <= 1'b1;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
